// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared types and helpers for the sequential shift-and-add multiplier.
//   mul_state_e : multiplier FSM state encoding (IDLE / CALC / DONE)
//   cnt_width() : width of the step counter able to hold 0..W
// ---------------------------------------------------------------------------
package mul_pkg;

   typedef enum logic [1:0] {MUL_IDLE, MUL_CALC, MUL_DONE} mul_state_e;

   // Step counter must represent the values 0..w inclusive.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/adder_xbit_ahead.sv
// ---------------------------------------------------------------------------
// adder_xbit_ahead
// Parameterised carry-lookahead adder built from 4-bit lookahead groups.
// Ports:
//   i_a, i_b  [DATA_WIDTH-1:0]  addends
//   i_cry                        carry in
//   o_sum     [DATA_WIDTH-1:0]  sum
//   o_cry                        carry out of the top bit
// Widths that are not a multiple of 4 are zero-padded internally.
// ---------------------------------------------------------------------------
module adder_xbit_ahead #(
   parameter int DATA_WIDTH = 16
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic                  i_cry,
   output logic [DATA_WIDTH-1:0] o_sum,
   output logic                  o_cry
);

   localparam int NG = (DATA_WIDTH + 3) / 4;
   localparam int PW = NG * 4;

   logic [PW-1:0] a_p;
   logic [PW-1:0] b_p;
   logic [PW-1:0] gen;
   logic [PW-1:0] prop;
   logic [PW-1:0] sum_p;
   logic [PW:0]   cry;

   // Carries c1..c4 of one 4-bit group, all derived directly from the
   // group's carry in rather than rippled bit by bit.
   function automatic logic [3:0] cla4(input logic [3:0] g,
                                       input logic [3:0] p,
                                       input logic       ci);
      logic [3:0] c;
      c[0] = g[0] | (p[0] & ci);
      c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & ci);
      c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
      return c;
   endfunction

   always_comb begin
      a_p = '0;
      b_p = '0;
      a_p[DATA_WIDTH-1:0] = i_a;
      b_p[DATA_WIDTH-1:0] = i_b;
   end

   assign gen  = a_p & b_p;
   assign prop = a_p ^ b_p;

   always_comb begin
      cry    = '0;
      cry[0] = i_cry;
      for (int k = 0; k < NG; k++) begin
         cry[4*k+1 +: 4] = cla4(gen[4*k +: 4], prop[4*k +: 4], cry[4*k]);
      end
   end

   assign sum_p = prop ^ cry[PW-1:0];
   assign o_sum = sum_p[DATA_WIDTH-1:0];
   // Per-bit carries make cry[DATA_WIDTH] the true carry even when padded.
   assign o_cry = cry[DATA_WIDTH];

endmodule

// File: rtl/mul_xbit_shift.sv
// ---------------------------------------------------------------------------
// mul_xbit_shift
// Sequential unsigned shift-and-add multiplier: one multiplier bit per cycle,
// each step adding the shifted multiplicand through a 2W carry-lookahead adder.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_valid / o_ready              operand handshake (o_ready only in IDLE)
//   i_num_a, i_num_b [W-1:0]       multiplicand / multiplier, unsigned
//   o_valid / i_ready              result handshake (o_valid only in DONE)
//   o_res [2W-1:0]                 product, meaningful while o_valid=1
//   o_dbg_state                    current FSM state for observation
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready/valid outputs decode registered state only, so there is
// no combinational path from i_valid/i_ready to any output.
// Build option: define MUL_XBIT_SHIFT_EARLY_EXIT_EN to finish as soon as
// the remaining multiplier bits are all zero (b=0 goes straight to DONE).
// ---------------------------------------------------------------------------
module mul_xbit_shift
   import mul_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [DATA_WIDTH-1:0]   i_num_a,
   input  logic [DATA_WIDTH-1:0]   i_num_b,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [2*DATA_WIDTH-1:0] o_res,
   output mul_state_e              o_dbg_state
);

   localparam int CNT_W = cnt_width(DATA_WIDTH);
   localparam int RW    = 2 * DATA_WIDTH;

   mul_state_e            state;
   logic [RW-1:0]         r_mcand;
   logic [DATA_WIDTH-1:0] r_mplier;
   logic [RW-1:0]         r_acc;
   logic [CNT_W-1:0]      r_cnt;
   logic [RW-1:0]         add_sum;
   logic                  last_step;

   // Product fits in 2W bits, so the adder's carry out is never needed.
   adder_xbit_ahead #(
      .DATA_WIDTH (RW)
   ) u_adder (
      .i_a   (r_acc),
      .i_b   (r_mcand),
      .i_cry (1'b0),
      .o_sum (add_sum),
      .o_cry ()
   );

`ifdef MUL_XBIT_SHIFT_EARLY_EXIT_EN
   // Stop once the multiplier left after this shift has no set bits; r_cnt
   // still bounds the number of steps.
   assign last_step = (r_cnt == CNT_W'(DATA_WIDTH - 1)) ||
                      (r_mplier[DATA_WIDTH-1:1] == '0);
`else
   assign last_step = (r_cnt == CNT_W'(DATA_WIDTH - 1));
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= MUL_IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else begin
         case (state)
            MUL_IDLE: begin
               if (i_valid) begin
                  r_mcand  <= {{DATA_WIDTH{1'b0}}, i_num_a};
                  r_mplier <= i_num_b;
                  r_acc    <= '0;
                  r_cnt    <= '0;
`ifdef MUL_XBIT_SHIFT_EARLY_EXIT_EN
                  state    <= (i_num_b == '0) ? MUL_DONE : MUL_CALC;
`else
                  state    <= MUL_CALC;
`endif
               end
            end
            MUL_CALC: begin
               if (r_mplier[0]) begin
                  r_acc <= add_sum;
               end
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (last_step) begin
                  state <= MUL_DONE;
               end
            end
            MUL_DONE: begin
               if (i_ready) begin
                  state <= MUL_IDLE;
               end
            end
            default: state <= MUL_IDLE;
         endcase
      end
   end

   assign o_ready     = (state == MUL_IDLE);
   assign o_valid     = (state == MUL_DONE);
   assign o_res       = r_acc;
   assign o_dbg_state = state;

endmodule

// File: tb/tb_mul_xbit_shift.sv
// ---------------------------------------------------------------------------
// tb_mul_xbit_shift
// Directed bench for mul_xbit_shift (W=8). Products and latencies are
// hand-computed; the expected product of each accepted operation is queued
// at the accept edge and popped when o_valid is observed.
// ---------------------------------------------------------------------------
module tb_mul_xbit_shift;
   import mul_pkg::*;

   localparam int W = 8;

`ifdef MUL_XBIT_SHIFT_EARLY_EXIT_EN
   localparam int LAT_3_5    = 3;
   localparam int LAT_FF     = 8;
   localparam int LAT_10     = 4;
   localparam int LAT_9      = 4;
   localparam int LAT_3      = 2;
   localparam int LAT_0      = 0;  // straight to DONE on the accept edge
   localparam int LAT_80     = 8;
   localparam int LAT_C5     = 8;
`else
   localparam int LAT_3_5    = 8;
   localparam int LAT_FF     = 8;
   localparam int LAT_10     = 8;
   localparam int LAT_9      = 8;
   localparam int LAT_3      = 8;
   localparam int LAT_0      = 8;
   localparam int LAT_80     = 8;
   localparam int LAT_C5     = 8;
`endif

   logic           i_clk = 1'b0;
   logic           i_rst_n;
   logic           i_valid;
   logic           o_ready;
   logic [W-1:0]   i_num_a;
   logic [W-1:0]   i_num_b;
   logic           o_valid;
   logic           i_ready;
   logic [2*W-1:0] o_res;
   mul_state_e     o_dbg_state;

   logic [2*W-1:0] exp_q[$];
   int             n_cmp = 0;
   int             n_err = 0;

   mul_xbit_shift #(
      .DATA_WIDTH (W)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_num_a     (i_num_a),
      .i_num_b     (i_num_b),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_res       (o_res),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- clock ----------------
   always #5 i_clk = ~i_clk;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Issue one operation, wait for the result, optionally hold backpressure
   // for 'hold' cycles in DONE, then release and confirm the return to IDLE.
   task automatic run_op(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp,
                         input int exp_lat, input int hold, input bit stir);
      int lat;
      int guard;
      bit rdy_seen;
      logic [2*W-1:0] want;
      @(negedge i_clk);
      guard = 0;
      while (!o_ready && guard < 40) begin
         @(negedge i_clk);
         guard++;
      end
      check({tag, "_ready"}, o_ready, 1'b1);
      i_ready = (hold == 0);
      i_valid = 1'b1;
      i_num_a = a;
      i_num_b = b;
      @(posedge i_clk);
      exp_q.push_back(exp);
      #1;
      i_valid  = 1'b0;
      lat      = 0;
      rdy_seen = 1'b0;
      while (!o_valid && lat < 40) begin
         if (o_ready) rdy_seen = 1'b1;
         if (stir) begin
            i_num_a = W'($urandom_range(0, 255));
            i_num_b = W'($urandom_range(0, 255));
         end
         @(posedge i_clk);
         #1;
         lat++;
      end
      check({tag, "_valid"}, o_valid, 1'b1);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_rdy_low"}, rdy_seen, 1'b0);
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check({tag, "_res"}, o_res, want);
      for (int i = 0; i < hold; i++) begin
         @(posedge i_clk);
         #1;
         check({tag, "_bp_valid"}, o_valid, 1'b1);
         check({tag, "_bp_res"}, o_res, want);
      end
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      check({tag, "_release_valid"}, o_valid, 1'b0);
      check({tag, "_release_ready"}, o_ready, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_num_a = '0;
      i_num_b = '0;
      #12;
      check("rst_ready", o_ready, 1'b1);
      check("rst_valid", o_valid, 1'b0);
      check("rst_res", o_res, 16'd0);
      check("rst_state", o_dbg_state, MUL_IDLE);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      run_op("basic",  8'd3,   8'd5,   16'd15,    LAT_3_5, 0, 1'b0);
      run_op("max",    8'd255, 8'd255, 16'hFE01,  LAT_FF,  0, 1'b0);
      run_op("bp",     8'd12,  8'd10,  16'd120,   LAT_10,  5, 1'b0);
      run_op("ee_b3",  8'd200, 8'd3,   16'd600,   LAT_3,   0, 1'b0);
      run_op("ee_b0",  8'd200, 8'd0,   16'd0,     LAT_0,   0, 1'b0);
      run_op("ee_b80", 8'd200, 8'h80,  16'h6400,  LAT_80,  0, 1'b0);
      run_op("stir",   8'h9C,  8'hC5,  16'h780C,  LAT_C5,  0, 1'b1);

      // Reset in the middle of CALC: abort immediately, no result.
      @(negedge i_clk);
      i_ready = 1'b1;
      i_valid = 1'b1;
      i_num_a = 8'h5A;
      i_num_b = 8'hFF;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      check("mid_calc_state", o_dbg_state, MUL_CALC);
      for (int i = 0; i < 4; i++) @(posedge i_clk);
      #2;
      check("mid_calc_acc_busy", (o_res != 16'd0), 1'b1);
      i_rst_n = 1'b0;
      #1;
      check("rst_mid_valid", o_valid, 1'b0);
      check("rst_mid_ready", o_ready, 1'b1);
      check("rst_mid_res", o_res, 16'd0);
      check("rst_mid_state", o_dbg_state, MUL_IDLE);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      run_op("post_rst", 8'd7, 8'd9, 16'd63, LAT_9, 0, 1'b0);

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
